instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_fetch_buf.sv | 38 +++
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, fetch FSM states and the default boot address.
package riscv_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // Instructions are 32-bit words, so any target with low address bits set is unusable.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction-memory request channel plus the fetch-to-decode channel.
interface instr_fetch_if;

    // Both channels use valid/ready: a transfer happens on a rising edge where the
    // producer's valid (imem_req / if_valid) and the consumer's ready (imem_ready /
    // id_ready) are both high; the producer keeps valid and its payload stable until then.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode,
        input  imem_ready, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode,
        output imem_ready, imem_rdata, id_ready
    );

endinterface

// File: rtl/instr_fetch_buf.sv
// One-entry instruction/pc holding register between instruction memory and decode.
module fetch_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        out_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    // Payload is left in place when the entry empties; only valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
        end else if (in_valid) begin
            valid_q <= 1'b1;
            instr_q <= in_instr;
            pc_q    <= in_pc;
        end else if (flush || (valid_q && out_ready)) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, redirect/flush handling, halt on SYSTEM and sticky misalignment fault.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          halted,
    output logic          fault,
    output fetch_state_t  state
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  redir_pc_q;
    logic         flush_q;
    logic         req_q;
    logic         halted_q;
    logic         fault_q;

    logic         buf_valid;
    logic [31:0]  buf_instr;
    logic [31:0]  buf_pc;

    logic         live;
    logic         bad_redirect;
    logic         mem_done;
    logic         buf_load;
    logic         buf_accept;
    logic         buf_flush;

    assign live         = (state_q == REQ) || (state_q == HOLD);
    assign bad_redirect = live && redirect && is_misaligned(redirect_pc);
    assign mem_done     = (state_q == REQ) && bus.imem_ready;
    assign buf_load     = mem_done && !flush_q && !redirect;
    assign buf_accept   = (state_q == HOLD) && bus.id_ready;
    assign buf_flush    = (state_q == HOLD) && redirect;

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (buf_load),
        .in_instr  (bus.imem_rdata),
        .in_pc     (pc_q),
        .out_ready (buf_accept),
        .flush     (buf_flush),
        .out_valid (buf_valid),
        .out_instr (buf_instr),
        .out_pc    (buf_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            redir_pc_q <= 32'h0;
            flush_q    <= 1'b0;
            req_q      <= 1'b1;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else if (bad_redirect) begin
            state_q  <= FAULT;
            flush_q  <= 1'b0;
            req_q    <= 1'b0;
            fault_q  <= 1'b1;
        end else begin
            case (state_q)
                REQ: begin
                    // The address on the bus stays put until memory answers; a redirect
                    // seen meanwhile is parked and the returning word thrown away.
                    if (bus.imem_ready) begin
                        if (redirect) begin
                            pc_q    <= redirect_pc;
                            flush_q <= 1'b0;
                        end else if (flush_q) begin
                            pc_q    <= redir_pc_q;
                            flush_q <= 1'b0;
                        end else begin
                            state_q <= HOLD;
                            req_q   <= 1'b0;
                        end
                    end else if (redirect) begin
                        redir_pc_q <= redirect_pc;
                        flush_q    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_q    <= redirect_pc;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end else if (bus.id_ready) begin
                        pc_q <= 32'(buf_pc + 32'd4);
                        if (buf_instr[6:0] == OPC_SYSTEM) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                HALT:    state_q <= HALT;
                FAULT:   state_q <= FAULT;
                default: state_q <= FAULT;
            endcase
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = buf_valid;
    assign bus.if_instr  = buf_instr;
    assign bus.if_pc     = buf_pc;
    assign bus.if_opcode = buf_instr[6:0];

    assign halted = halted_q;
    assign fault  = fault_q;
    assign state  = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model, decode-side scoreboard and per-feature scenarios.
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic         clk;
    logic         rst;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         halted;
    logic         fault;
    fetch_state_t state;
    logic [31:0]  ecall_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(TB_RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted),
        .fault       (fault),
        .state       (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory model: each word encodes its own address, except the chosen ecall slot.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] ec);
        if (a == ec) return 32'h0000_0073;
        return {a[24:0], OPC_I};
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr, ecall_pc);

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && bus.if_valid && bus.id_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_unexpected: got pc=%h instr=%h, required no accepted instruction",
                         bus.if_pc, bus.if_instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if ({bus.if_pc, bus.if_instr} !== e) begin
                    n_fail++;
                    $display("FAIL accept_data: got pc=%h instr=%h, required pc=%h instr=%h",
                             bus.if_pc, bus.if_instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.imem_ready  = 1'b0;
        bus.id_ready    = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_fetch(input logic [31:0] a);
        exp_q.push_back({a, mem_word(a, ecall_pc)});
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ecall_pc = 32'hDEAD_BEE0;
        rst = 1'b1;
        bus.imem_ready = 1'b0;
        bus.id_ready   = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req: got %b required 1", bus.imem_req); end
        n_checks++; if (bus.imem_addr !== TB_RESET_PC) begin n_fail++; $display("FAIL rst_addr: got %h required %h", bus.imem_addr, TB_RESET_PC); end
        n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", bus.if_valid); end
        n_checks++; if (bus.if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h required 0", bus.if_instr); end
        n_checks++; if (bus.if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h required 0", bus.if_pc); end
        n_checks++; if (bus.if_opcode !== 7'h0) begin n_fail++; $display("FAIL rst_opcode: got %h required 0", bus.if_opcode); end
        n_checks++; if (halted !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got halted=%b fault=%b required 0 0", halted, fault); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        bus.imem_ready = 1'b1;
        bus.id_ready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== a) begin n_fail++; $display("FAIL seq_addr: got req=%b addr=%h required 1 %h", bus.imem_req, bus.imem_addr, a); end
            push_fetch(a);
            tick();
            n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== a) begin n_fail++; $display("FAIL seq_out: got valid=%b pc=%h required 1 %h", bus.if_valid, bus.if_pc, a); end
            n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_idle: got req=%b required 0", bus.imem_req); end
            tick();
        end
        bus.imem_ready = 1'b0;
        n_checks++; if (bus.imem_addr !== 32'hC || bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL seq_next: got addr=%h valid=%b required c 0", bus.imem_addr, bus.if_valid); end
    endtask

    task automatic test_stall();
        logic [31:0] w;
        w = mem_word(32'hC, ecall_pc);
        bus.id_ready   = 1'b0;
        bus.imem_ready = 1'b1;
        push_fetch(32'hC);
        tick();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hC || bus.if_instr !== w || bus.imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: got valid=%b pc=%h instr=%h req=%b required 1 c %h 0",
                         bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_req, w);
            end
            tick();
        end
        bus.id_ready = 1'b1;
        tick();
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got req=%b addr=%h valid=%b required 1 10 0", bus.imem_req, bus.imem_addr, bus.if_valid); end
    endtask

    task automatic test_redirect_flush();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL flush_stable: got req=%b addr=%h required 1 10", bus.imem_req, bus.imem_addr); end
            tick();
        end
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL flush_target: got valid=%b addr=%h req=%b required 0 100 1", bus.if_valid, bus.imem_addr, bus.imem_req); end
        push_fetch(32'h100);
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100) begin n_fail++; $display("FAIL flush_refetch: got valid=%b pc=%h required 1 100", bus.if_valid, bus.if_pc); end
        tick();
        // Two redirects while the request is outstanding: the later one wins.
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h340;
        tick();
        redirect = 1'b0;
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        n_checks++; if (bus.imem_addr !== 32'h340 || bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL latest_redirect: got addr=%h valid=%b required 340 0", bus.imem_addr, bus.if_valid); end
    endtask

    task automatic test_hold_redirect();
        bus.id_ready   = 1'b0;
        bus.imem_ready = 1'b1;
        push_fetch(32'h340);
        tick();
        bus.imem_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h40; bus.id_ready = 1'b1;
        tick();
        redirect = 1'b0; bus.id_ready = 1'b0;
        n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h40 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL hold_redir_accept: got valid=%b addr=%h req=%b required 0 40 1", bus.if_valid, bus.imem_addr, bus.imem_req); end
        // Held word discarded: redirect without id_ready.
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h40) begin n_fail++; $display("FAIL hold_fetch40: got valid=%b pc=%h required 1 40", bus.if_valid, bus.if_pc); end
        redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h80) begin n_fail++; $display("FAIL hold_redir_discard: got valid=%b addr=%h required 0 80", bus.if_valid, bus.imem_addr); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; bus.imem_ready = 1'b1;
        tick();
        redirect = 1'b0;
        n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL coincident_redirect: got valid=%b addr=%h required 0 fffffffc", bus.if_valid, bus.imem_addr); end
        push_fetch(32'hFFFF_FFFC);
        bus.id_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        n_checks++; if (bus.if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h required fffffffc", bus.if_pc); end
        tick();
        n_checks++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_next: got addr=%h req=%b required 0 1", bus.imem_addr, bus.imem_req); end
    endtask

    task automatic test_halt();
        ecall_pc = 32'h0;
        push_fetch(32'h0);
        bus.imem_ready = 1'b1;
        bus.id_ready   = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        n_checks++; if (bus.if_opcode !== OPC_SYSTEM) begin n_fail++; $display("FAIL halt_opcode: got %b required %b", bus.if_opcode, OPC_SYSTEM); end
        tick();
        n_checks++; if (halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL halt_enter: got halted=%b req=%b valid=%b required 1 0 0", halted, bus.imem_req, bus.if_valid); end
        redirect = 1'b1; redirect_pc = 32'h10; bus.imem_ready = 1'b1;
        tick();
        redirect = 1'b0; bus.imem_ready = 1'b0;
        tick();
        n_checks++; if (halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL halt_sticky: got halted=%b req=%b valid=%b required 1 0 0", halted, bus.imem_req, bus.if_valid); end
        ecall_pc = 32'hDEAD_BEE0;
        do_reset();
        n_checks++; if (halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== TB_RESET_PC || bus.if_instr !== 32'h0) begin n_fail++; $display("FAIL halt_reset: got halted=%b req=%b addr=%h instr=%h required 0 1 %h 0", halted, bus.imem_req, bus.imem_addr, bus.if_instr, TB_RESET_PC); end
    endtask

    task automatic test_fault();
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        n_checks++; if (fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL fault_enter: got fault=%b req=%b valid=%b required 1 0 0", fault, bus.imem_req, bus.if_valid); end
        bus.imem_ready = 1'b1; bus.id_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        tick();
        redirect = 1'b0; bus.imem_ready = 1'b0;
        n_checks++; if (fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL fault_sticky: got fault=%b req=%b valid=%b required 1 0 0", fault, bus.imem_req, bus.if_valid); end
        do_reset();
        n_checks++; if (fault !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== TB_RESET_PC) begin n_fail++; $display("FAIL fault_reset: got fault=%b req=%b addr=%h required 0 1 %h", fault, bus.imem_req, bus.imem_addr, TB_RESET_PC); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_flush();
        test_hold_redirect();
        test_wrap();
        test_halt();
        test_fault();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
